// File: rtl/rbcp_reg_slave.sv
`timescale 1ns/1ps
// rbcp_reg_slave
//   SiTCP RBCP register slave serving a 256-byte window at BASE_ADDR.
//   0x00..0x0F  control registers (REG_OUT)
//   0x10..0x17  read-only STATUS_IN bytes
//   0x18        write-to-pulse command byte (CMD_PULSE)
//   0x1F        ID_CODE
//   others      ACKed, read 0x00, writes ignored
//   Every accepted access is acknowledged exactly two cycles after its strobe.
//
// Ports
//   CLK, RST                     clock, synchronous active-high reset
//   RBCP_ACT/ADDR/WD/WE/RE       RBCP request side
//   RBCP_ACK, RBCP_RD            acknowledge pulse and read data (0 when no ACK)
//   REG_OUT[127:0]               control registers, byte k at [8k+7:8k]
//   STATUS_IN[63:0]              status bytes, byte k at offset 0x10+k
//   CMD_PULSE[7:0]               one-cycle command bits, coincident with ACK
//
// Build option
//   RBCP_REG_READBACK_EN  when defined, control registers read back their
//                         current value; otherwise they read 0x00.
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | waiting for a strobe that hits the window
// ST_LATCH | request captured; commit write, fetch read data
// ST_ACK   | RBCP_ACK high for this one cycle

module rbcp_reg_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [7:0]  ID_CODE   = 8'hA5
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         RBCP_ACT,
    input  logic [31:0]  RBCP_ADDR,
    input  logic [7:0]   RBCP_WD,
    input  logic         RBCP_WE,
    input  logic         RBCP_RE,
    output logic         RBCP_ACK,
    output logic [7:0]   RBCP_RD,
    output logic [127:0] REG_OUT,
    input  logic [63:0]  STATUS_IN,
    output logic [7:0]   CMD_PULSE
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LATCH = 2'd1;
    localparam logic [1:0] ST_ACK   = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [7:0]   off_q, off_d;
    logic [7:0]   wd_q, wd_d;
    logic         wr_q, wr_d;
    logic         ack_q, ack_d;
    logic [7:0]   rd_q, rd_d;
    logic [7:0]   cmd_q, cmd_d;
    logic [127:0] reg_q, reg_d;

    logic         hit;
    logic [7:0]   read_val;

    assign hit = (RBCP_ADDR[31:8] == BASE_ADDR[31:8]);

    always_comb begin
        read_val = 8'h00;
        if (off_q[7:4] == 4'h0) begin
`ifdef RBCP_REG_READBACK_EN
            read_val = reg_q[{off_q[3:0], 3'b000} +: 8];
`else
            read_val = 8'h00;
`endif
        end else if (off_q[7:3] == 5'b0001_0) begin
            read_val = STATUS_IN[{off_q[2:0], 3'b000} +: 8];
        end else if (off_q == 8'h1F) begin
            read_val = ID_CODE;
        end
    end

    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        wd_d    = wd_q;
        wr_d    = wr_q;
        reg_d   = reg_q;
        ack_d   = 1'b0;
        rd_d    = 8'h00;
        cmd_d   = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if ((RBCP_WE | RBCP_RE) & RBCP_ACT & hit) begin
                    off_d   = RBCP_ADDR[7:0];
                    wd_d    = RBCP_WD;
                    wr_d    = RBCP_WE;   // WE wins when both strobes arrive
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                // The commit does not depend on ACT: a write dropped by the
                // master in this cycle still takes effect, only the ACK is lost.
                if (wr_q && off_q[7:4] == 4'h0) begin
                    reg_d[{off_q[3:0], 3'b000} +: 8] = wd_q;
                end
                if (RBCP_ACT) begin
                    ack_d   = 1'b1;
                    state_d = ST_ACK;
                    if (!wr_q) begin
                        rd_d = read_val;
                    end
                    if (wr_q && off_q == 8'h18) begin
                        cmd_d = wd_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            off_q   <= 8'h00;
            wd_q    <= 8'h00;
            wr_q    <= 1'b0;
            ack_q   <= 1'b0;
            rd_q    <= 8'h00;
            cmd_q   <= 8'h00;
            reg_q   <= 128'h0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            wd_q    <= wd_d;
            wr_q    <= wr_d;
            ack_q   <= ack_d;
            rd_q    <= rd_d;
            cmd_q   <= cmd_d;
            reg_q   <= reg_d;
        end
    end

    assign RBCP_ACK  = ack_q;
    assign RBCP_RD   = rd_q;
    assign CMD_PULSE = cmd_q;
    assign REG_OUT   = reg_q;

endmodule

// File: tb/tb_rbcp_reg_slave.sv
`timescale 1ns/1ps
// Testbench for rbcp_reg_slave: directed literal checks followed by random
// traffic, all checked every cycle against a transaction-level model.

module tb_rbcp_reg_slave;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [7:0]  ID   = 8'hA5;
`ifdef RBCP_REG_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         RBCP_ACT = 1'b0;
    logic [31:0]  RBCP_ADDR = 32'h0;
    logic [7:0]   RBCP_WD = 8'h0;
    logic         RBCP_WE = 1'b0;
    logic         RBCP_RE = 1'b0;
    logic         RBCP_ACK;
    logic [7:0]   RBCP_RD;
    logic [127:0] REG_OUT;
    logic [63:0]  STATUS_IN = 64'h0;
    logic [7:0]   CMD_PULSE;

    int checks = 0;
    int errors = 0;

    rbcp_reg_slave #(.BASE_ADDR(BASE), .ID_CODE(ID)) dut (
        .CLK(CLK), .RST(RST), .RBCP_ACT(RBCP_ACT), .RBCP_ADDR(RBCP_ADDR),
        .RBCP_WD(RBCP_WD), .RBCP_WE(RBCP_WE), .RBCP_RE(RBCP_RE),
        .RBCP_ACK(RBCP_ACK), .RBCP_RD(RBCP_RD), .REG_OUT(REG_OUT),
        .STATUS_IN(STATUS_IN), .CMD_PULSE(CMD_PULSE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // An accepted request at cycle c is answered at c+2 (if ACT is still high
    // at c+1); no new request is taken until the answer cycle has passed.
    logic [7:0] m_reg [16];
    bit         m_valid = 1'b0;
    bit         m_ack;
    logic [7:0] m_rd, m_cmd;
    bit         m_pend;
    int         m_pend_cyc;
    bit         m_pend_we;
    logic [7:0] m_pend_off, m_pend_wd;
    int         m_busy_until;
    int         cyc = 0;

    function automatic logic [127:0] mreg_vec();
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[i*8 +: 8] = m_reg[i];
        return v;
    endfunction

    function automatic logic [7:0] model_read(input logic [7:0] off, input logic [63:0] st);
        if (off < 8'h10)      return RB ? m_reg[off[3:0]] : 8'h00;
        else if (off < 8'h18) return st[(off - 8'h10) * 8 +: 8];
        else if (off == 8'h1F) return ID;
        else                  return 8'h00;
    endfunction

    always @(negedge CLK) begin
        logic       n_ack;
        logic [7:0] n_rd, n_cmd;
        if (m_valid) begin
            chk("ack", 128'(RBCP_ACK), 128'(m_ack));
            chk("rd", 128'(RBCP_RD), 128'(m_rd));
            chk("cmd", 128'(CMD_PULSE), 128'(m_cmd));
            chk("reg_out", REG_OUT, mreg_vec());
        end
        n_ack = 1'b0;
        n_rd  = 8'h00;
        n_cmd = 8'h00;
        if (RST) begin
            for (int i = 0; i < 16; i++) m_reg[i] = 8'h00;
            m_pend       = 1'b0;
            m_busy_until = cyc;
            m_valid      = 1'b1;
        end else if (m_valid) begin
            if (m_pend && m_pend_cyc == cyc - 1) begin
                if (m_pend_we && m_pend_off < 8'h10) m_reg[m_pend_off[3:0]] = m_pend_wd;
                if (RBCP_ACT) begin
                    n_ack = 1'b1;
                    n_rd  = m_pend_we ? 8'h00 : model_read(m_pend_off, STATUS_IN);
                    n_cmd = (m_pend_we && m_pend_off == 8'h18) ? m_pend_wd : 8'h00;
                    m_busy_until = cyc + 1;
                end else begin
                    m_busy_until = cyc;
                end
                m_pend = 1'b0;
            end else if (!m_pend && cyc > m_busy_until && (RBCP_WE || RBCP_RE) && RBCP_ACT
                         && RBCP_ADDR[31:8] == BASE[31:8]) begin
                m_pend     = 1'b1;
                m_pend_cyc = cyc;
                m_pend_we  = RBCP_WE;
                m_pend_off = RBCP_ADDR[7:0];
                m_pend_wd  = RBCP_WD;
            end
        end
        m_ack = n_ack;
        m_rd  = n_rd;
        m_cmd = n_cmd;
        cyc++;
    end

    // ---------------- directed helpers ----------------
    task automatic txn(input logic we, input logic re, input logic [31:0] addr,
                       input logic [7:0] wd, output int lat, output logic [7:0] rd,
                       output logic [7:0] cmd, output logic [7:0] cmd_nx,
                       output logic [127:0] ro);
        lat = -1; rd = 8'h00; cmd = 8'h00; cmd_nx = 8'h00; ro = 128'h0;
        @(posedge CLK); #1;
        RBCP_ACT = 1'b1; RBCP_WE = we; RBCP_RE = re; RBCP_ADDR = addr; RBCP_WD = wd;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            if (lat >= 0 && k == lat + 1) cmd_nx = CMD_PULSE;
            if (lat < 0 && RBCP_ACK) begin
                lat = k; rd = RBCP_RD; cmd = CMD_PULSE; ro = REG_OUT;
            end
            if (k == 0) begin
                @(posedge CLK); #1;
                RBCP_WE = 1'b0; RBCP_RE = 1'b0;
            end
        end
        @(posedge CLK); #1;
        RBCP_ACT = 1'b0;
    endtask

    initial begin
        int lat, acks;
        logic [7:0] rd, cmd, cmd_nx;
        logic [127:0] ro;

        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("reset_reg_out", REG_OUT, 128'h0);
        chk("reset_ack", 128'(RBCP_ACK), 128'h0);
        chk("reset_rd", 128'(RBCP_RD), 128'h0);
        chk("reset_cmd", 128'(CMD_PULSE), 128'h0);

        txn(1'b1, 1'b0, BASE + 32'h03, 8'h5A, lat, rd, cmd, cmd_nx, ro);
        chk("wr03_latency", 128'(lat), 128'(2));
        chk("wr03_reg_at_ack", 128'(ro[31:24]), 128'h5A);

        txn(1'b0, 1'b1, BASE + 32'h03, 8'h00, lat, rd, cmd, cmd_nx, ro);
        chk("rd03_latency", 128'(lat), 128'(2));
        chk("rd03_data", 128'(rd), RB ? 128'h5A : 128'h00);

        STATUS_IN = 64'h0807060504030201;
        txn(1'b0, 1'b1, BASE + 32'h12, 8'h00, lat, rd, cmd, cmd_nx, ro);
        chk("rd12_data", 128'(rd), 128'h03);
        txn(1'b1, 1'b0, BASE + 32'h12, 8'hFF, lat, rd, cmd, cmd_nx, ro);
        chk("wr12_latency", 128'(lat), 128'(2));
        txn(1'b0, 1'b1, BASE + 32'h12, 8'h00, lat, rd, cmd, cmd_nx, ro);
        chk("rd12_after_wr", 128'(rd), 128'h03);

        txn(1'b1, 1'b0, BASE + 32'h18, 8'h81, lat, rd, cmd, cmd_nx, ro);
        chk("cmd_at_ack", 128'(cmd), 128'h81);
        chk("cmd_after_ack", 128'(cmd_nx), 128'h00);
        txn(1'b0, 1'b1, BASE + 32'h18, 8'h00, lat, rd, cmd, cmd_nx, ro);
        chk("rd18_zero", 128'(rd), 128'h00);
        txn(1'b0, 1'b1, BASE + 32'h1F, 8'h00, lat, rd, cmd, cmd_nx, ro);
        chk("rd1f_id", 128'(rd), 128'hA5);

        txn(1'b0, 1'b1, 32'h0000_2003, 8'h00, lat, rd, cmd, cmd_nx, ro);
        chk("miss_no_ack", 128'(lat), 128'(-1));
        txn(1'b0, 1'b1, 32'h0000_1003, 8'h00, lat, rd, cmd, cmd_nx, ro);
        chk("hit_ack", 128'(lat), 128'(2));

        // WE+RE together, then a second WE one cycle later
        @(posedge CLK); #1;
        RBCP_ACT = 1'b1; RBCP_WE = 1'b1; RBCP_RE = 1'b1; RBCP_ADDR = BASE + 32'h05; RBCP_WD = 8'h11;
        @(posedge CLK); #1;
        RBCP_RE = 1'b0; RBCP_ADDR = BASE + 32'h06; RBCP_WD = 8'h22;
        @(posedge CLK); #1;
        RBCP_WE = 1'b0;
        acks = 1;
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (RBCP_ACK) acks++;
        end
        chk("dual_strobe_acks", 128'(acks), 128'(1));
        chk("dual_first_committed", 128'(REG_OUT[47:40]), 128'h11);
        chk("dual_second_dropped", 128'(REG_OUT[55:48]), 128'h00);

        // reset during LATCH
        @(posedge CLK); #1;
        RBCP_WE = 1'b1; RBCP_ADDR = BASE + 32'h07; RBCP_WD = 8'h33;
        @(posedge CLK); #1;
        RBCP_WE = 1'b0; RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        acks = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            if (RBCP_ACK) acks++;
        end
        chk("rst_latch_no_ack", 128'(acks), 128'(0));
        chk("rst_latch_reg_out", REG_OUT, 128'h0);
        @(posedge CLK); #1;
        RBCP_ACT = 1'b0;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            @(posedge CLK); #1;
            RST       = ($urandom_range(0, 99) == 0);
            RBCP_ACT  = ($urandom_range(0, 9) != 0);
            RBCP_WE   = ($urandom_range(0, 3) == 0);
            RBCP_RE   = ($urandom_range(0, 3) == 0);
            RBCP_WD   = 8'($urandom);
            STATUS_IN = {$urandom, $urandom};
            r = $urandom_range(0, 9);
            if (r < 6)      RBCP_ADDR = {BASE[31:8], 3'b000, 5'($urandom)};
            else if (r < 8) RBCP_ADDR = {BASE[31:8], 8'($urandom)};
            else            RBCP_ADDR = $urandom;
        end
        @(posedge CLK); #1;
        RST = 1'b0; RBCP_WE = 1'b0; RBCP_RE = 1'b0; RBCP_ACT = 1'b0;
        repeat (4) @(posedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
